// File: rtl/inv_solver_pkg.sv
// Shared types and the reference predicate P(x) = signed((x << s) mod 2^w) > signed(t).
package inv_solver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        CHECK,
        SEARCH,
        RESP
    } state_t;

    // Operands are zero-extended to 32 bits; w must be below 32.
    // The signed compare flips the sign bit of both operands and compares them as unsigned.
    function automatic logic shl_sgt(
        input logic [31:0] x,
        input logic [31:0] s,
        input logic [31:0] t,
        input int          w
    );
        logic [31:0] mask;
        logic [31:0] sign;
        logic [31:0] sh;
        mask = (32'h1 << w) - 32'h1;
        sign = 32'h1 << (w - 1);
        sh   = (s >= $unsigned(w)) ? 32'h0 : ((x << s) & mask);
        return ((sh ^ sign) > ((t & mask) ^ sign));
    endfunction

endpackage

// File: rtl/inv_pred_bvsgt_bvshl.sv
// Combinational evaluator of (x << s) >s t at width W.
module inv_pred_bvsgt_bvshl
    import inv_solver_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         hit
);

    assign hit = shl_sgt(32'(x), 32'(s), 32'(t), W);

endmodule

// File: rtl/inv_bvsgt_bvshl_solver_ctrl.sv
// Query sequencer: runs the external Skolem evaluator, verifies its candidate, and
// falls back to an ascending exhaustive scan when the candidate fails.
//
// state  | meaning
// IDLE   | ready for a query
// EVAL   | waiting SK_LAT cycles for sk_x to settle
// CHECK  | verify the Skolem candidate
// SEARCH | scan x = 0 .. 2^W-1, one value per cycle
// RESP   | response held until rsp_ready
module inv_bvsgt_bvshl_solver_ctrl
    import inv_solver_pkg::*;
#(
    parameter int W      = 4,
    parameter int SK_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_s,
    input  logic [W-1:0] req_t,
    output logic [W-1:0] sk_s,
    output logic [W-1:0] sk_t,
    input  logic [W-1:0] sk_x,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_x,
    output logic         rsp_found,
    output logic         rsp_skolem,
    output logic [W+1:0] rsp_cycles
);

    localparam int           LW       = (SK_LAT > 1) ? $clog2(SK_LAT) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(SK_LAT - 1);
    localparam logic [W-1:0]  X_LAST   = '1;
    localparam logic [W+1:0]  CYC_MAX  = '1;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] lat;
    logic [W-1:0]  x_scan;
    logic [W-1:0]  pred_x;
    logic [W+1:0]  cyc;
    logic [W+1:0]  cyc_inc;
    logic          pred_hit;
    logic          accept;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign pred_x    = (state == CHECK) ? sk_x : x_scan;
    // cyc_inc already includes the current cycle, so it is what gets reported on exit
    assign cyc_inc   = (cyc == CYC_MAX) ? cyc : cyc + (W + 2)'(1);

    inv_pred_bvsgt_bvshl #(.W(W)) u_pred (
        .x   (pred_x),
        .s   (sk_s),
        .t   (sk_t),
        .hit (pred_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EVAL;
            EVAL:    if (lat == '0) state_nxt = CHECK;
            CHECK:   state_nxt = pred_hit ? RESP : SEARCH;
            SEARCH:  if (pred_hit || (x_scan == X_LAST)) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sk_s       <= '0;
            sk_t       <= '0;
            lat        <= '0;
            cyc        <= '0;
            x_scan     <= '0;
            rsp_x      <= '0;
            rsp_found  <= 1'b0;
            rsp_skolem <= 1'b0;
            rsp_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sk_s <= req_s;
                        sk_t <= req_t;
                        cyc  <= '0;
                        lat  <= LAT_LOAD;
                    end
                end
                EVAL: begin
                    cyc <= cyc_inc;
                    if (lat != '0) lat <= lat - LW'(1);
                end
                CHECK: begin
                    cyc    <= cyc_inc;
                    x_scan <= '0;
                    if (pred_hit) begin
                        rsp_x      <= sk_x;
                        rsp_found  <= 1'b1;
                        rsp_skolem <= 1'b1;
                        rsp_cycles <= cyc_inc;
                    end
                end
                SEARCH: begin
                    cyc    <= cyc_inc;
                    x_scan <= x_scan + W'(1);
                    if (pred_hit) begin
                        rsp_x      <= x_scan;
                        rsp_found  <= 1'b1;
                        rsp_skolem <= 1'b0;
                        rsp_cycles <= cyc_inc;
                    end else if (x_scan == X_LAST) begin
                        rsp_x      <= '0;
                        rsp_found  <= 1'b0;
                        rsp_skolem <= 1'b0;
                        rsp_cycles <= cyc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
